// File: rtl/cam_soc_mem_stream_reader_pkg.sv
// Shared types and defaults for the on-chip RAM stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_soc_stream_pkg;

  localparam int ADDR_W_DEF       = 10;
  localparam int DATA_W_DEF       = 32;
  localparam int READ_LATENCY_DEF = 1;
  localparam int FIFO_DEPTH_DEF   = 4;

  // Block-transfer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Full-word byte enable for the default data width
  localparam logic [DATA_W_DEF/8-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/cam_soc_mem_stream_reader_fifo.sv
// Generic synchronous FIFO (DATA_W x DEPTH, DEPTH a power of two), head is show-ahead.
// Latency: pushed word visible at head the cycle after the push edge.
// Backpressure: push ignored when full unless a pop frees the slot that cycle; pop ignored when empty.
module cam_soc_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array: written on accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cam_soc_mem_stream_reader.sv
// Avalon-MM read master: fetches word_count words from base_addr of the on-chip RAM and streams them out.
// Latency: first avm_chipselect 1 cycle after start; first st_valid READ_LATENCY+1 cycles after that.
// Backpressure: reads issue only while FIFO occupancy + in-flight reads < FIFO_DEPTH, so st_ready stalls never drop data.
// Build option CAM_SOC_STREAM_XOR_EN adds xor_key (latched on start); stream data is XORed with it.
module cam_soc_mem_stream_reader
  import cam_soc_stream_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_clken,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  output logic                st_last,
  input  logic                st_ready
`ifdef CAM_SOC_STREAM_XOR_EN
  ,
  input  logic [DATA_W-1:0]   xor_key
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W-1:0]     base_q;
  logic [ADDR_W:0]       count_q;
  logic [ADDR_W:0]       issued;
  logic [ADDR_W:0]       popped;
  logic [CNT_W-1:0]      outstanding;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic [CNT_W:0]        credits_used;
  logic                  start_ok;
  logic                  issue;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_W-1:0]     fifo_head;

  assign start_ok     = (state == IDLE) && start;
  assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding};
  // Credit check bounds FIFO fill; !fifo_full is a redundant guard against overflow
  assign issue        = (state == READ) && (issued != count_q) &&
                        (credits_used < (CNT_W+1)'(FIFO_DEPTH)) && !fifo_full;
  assign fifo_push    = rd_pipe[READ_LATENCY-1];
  assign st_valid     = !fifo_empty;
  assign fifo_pop     = st_valid && st_ready;
  assign st_last      = st_valid && (popped == count_q - (ADDR_W+1)'(1));

  assign avm_chipselect = issue;
  assign avm_address    = issue ? (base_q + issued[ADDR_W-1:0]) : '0;
  assign avm_clken      = 1'b1;

  generate
    if (DATA_W == DATA_W_DEF) begin : g_be_pkg
      assign avm_byteenable = issue ? BE_ALL_ONES : '0;
    end else begin : g_be_rep
      assign avm_byteenable = issue ? {(DATA_W/8){1'b1}} : '0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (word_count == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issued == count_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((outstanding == '0) && fifo_empty) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Transfer parameters and issue/pop progress counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q  <= '0;
      count_q <= '0;
      issued  <= '0;
      popped  <= '0;
    end else if (start_ok) begin
      base_q  <= base_addr;
      count_q <= word_count;
      issued  <= '0;
      popped  <= '0;
    end else begin
      if (issue)    issued <= issued + (ADDR_W+1)'(1);
      if (fifo_pop) popped <= popped + (ADDR_W+1)'(1);
    end
  end

  // Read-return tagging and in-flight read count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pipe     <= '0;
      outstanding <= '0;
    end else begin
      rd_pipe[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      case ({issue, fifo_push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  cam_soc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (avm_readdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef CAM_SOC_STREAM_XOR_EN
  logic [DATA_W-1:0] key_q;

  // Key captured with the transfer parameters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q <= '0;
    end else if (start_ok) begin
      key_q <= xor_key;
    end
  end

  assign st_data = fifo_head ^ key_q;
`else
  assign st_data = fifo_head;
`endif

endmodule

// File: tb/tb_cam_soc_mem_stream_reader.sv
module tb_cam_soc_mem_stream_reader;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   word_count = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic [3:0]        avm_byteenable;
  logic              avm_clken;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_last;
  logic              st_ready = 1'b1;
`ifdef CAM_SOC_STREAM_XOR_EN
  logic [DATA_W-1:0] xor_key = 32'hA5A5A5A5;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic [31:0]       ram [1024];
  exp_t              sb [$];
  logic [ADDR_W-1:0] addr_log [$];
  exp_t              e;
  logic [31:0]       key_exp;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int cs_cnt = 0;
  int pop_cnt = 0;
  int max_fill = 0;
  int ready_mode = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  cam_soc_mem_stream_reader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_byteenable (avm_byteenable),
    .avm_clken      (avm_clken),
    .avm_readdata   (avm_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_last        (st_last),
    .st_ready       (st_ready)
`ifdef CAM_SOC_STREAM_XOR_EN
    ,
    .xor_key        (xor_key)
`endif
  );

  // RAM slave model: one-cycle registered read
  always @(posedge clk) begin
    if (avm_chipselect) avm_readdata <= ram[avm_address];
  end

  // Ready pattern generator: mode 0 always ready, mode 1 repeats 1,0,0,1
  always @(posedge clk) begin
    #1;
    cyc++;
    if (ready_mode == 0) st_ready = 1'b1;
    else st_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: scoreboard pops, bus-side protocol checks, event counters
  always @(negedge clk) begin
    if (reset_n) begin
      if (avm_chipselect) begin
        cs_cnt++;
        addr_log.push_back(avm_address);
      end
      checks++;
      if (avm_byteenable !== (avm_chipselect ? 4'hF : 4'h0) || avm_clken !== 1'b1) begin
        errors++;
        $display("FAIL bus_strobes got be=%h clken=%b cs=%b", avm_byteenable, avm_clken, avm_chipselect);
      end
      if (st_valid) valid_cnt++;
      if (int'(dut.fifo_count) > max_fill) max_fill = int'(dut.fifo_count);
      if (dut.fifo_push && dut.fifo_full) begin
        errors++;
        $display("FAIL push_while_full got push=1 full=1 expected no push");
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_with_done got %b expected 1", busy);
        end
      end
      if (st_valid && st_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got data=%h last=%b expected none", st_data, st_last);
        end else begin
          e = sb.pop_front();
          checks++;
          if (st_data !== e.data || st_last !== e.last) begin
            errors++;
            $display("FAIL stream_word got data=%h last=%b expected data=%h last=%b",
                     st_data, st_last, e.data, e.last);
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = n;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 10'h155; word_count = 11'd7;
  endtask

  task automatic run_xfer(input logic [ADDR_W-1:0] b, input int n, input int mode, input bit nuisance);
    int   d0;
    exp_t t;
    d0 = done_cnt;
    ready_mode = mode;
    addr_log.delete();
    for (int i = 0; i < n; i++) begin
      t.data = ram[(int'(b) + i) % 1024] ^ key_exp;
      t.last = (i == n - 1);
      sb.push_back(t);
    end
    pulse_start(b, (ADDR_W+1)'(n));
    @(negedge clk);
    check("first_cs", avm_chipselect, 1);
    check("first_addr", avm_address, b);
    @(negedge clk);
    check("valid_not_yet", st_valid, 0);
    @(negedge clk);
    check("first_valid", st_valid, 1);
    if (nuisance) begin
      @(posedge clk); #1;
      start = 1'b1; base_addr = 10'h100; word_count = 11'd3;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(posedge clk);
    check("done_seen", done_cnt, d0 + 1);
    repeat (6) @(negedge clk);
    check("done_once", done_cnt, d0 + 1);
    check("busy_after", busy, 0);
    check("sb_empty", sb.size(), 0);
    check("issue_count", addr_log.size(), n);
  endtask

  initial begin
    logic [ADDR_W-1:0] wrap_exp [4];
    int d0;
    int c0;
    int v0;
    int p0;
    wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    for (int i = 0; i < 1024; i++) ram[i] = i;
`ifdef CAM_SOC_STREAM_XOR_EN
    key_exp = 32'hA5A5A5A5;
`else
    key_exp = 32'h0;
`endif
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs", avm_chipselect, 0);
    check("rst_valid", st_valid, 0);
    check("rst_addr", avm_address, 0);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic block, full throughput
    run_xfer(10'h010, 8, 0, 1'b0);
    // Same block under backpressure, with a start pulsed while busy
    run_xfer(10'h010, 8, 1, 1'b1);
    // Address wrap at top of RAM
    run_xfer(10'h3FE, 4, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (addr_log.size() > i) check("wrap_addr", addr_log[i], wrap_exp[i]);
    end

    // Zero-length transfer
    d0 = done_cnt; c0 = cs_cnt; v0 = valid_cnt;
    pulse_start(10'h005, 11'd0);
    @(negedge clk);
    check("zero_done_timing", done, 1);
    repeat (3) @(negedge clk);
    check("zero_done_once", done_cnt, d0 + 1);
    check("zero_no_cs", cs_cnt, c0);
    check("zero_no_valid", valid_cnt, v0);

    // Reset mid-transfer
    ready_mode = 0;
    d0 = done_cnt; p0 = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      e.data = (32'h20 + i) ^ key_exp;
      e.last = (i == 9);
      sb.push_back(e);
    end
    pulse_start(10'h020, 11'd10);
    for (int k = 0; k < 100 && pop_cnt < p0 + 3; k++) @(negedge clk);
    check("pre_reset_pops", pop_cnt, p0 + 3);
    #1 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", st_valid, 0);
    check("arst_cs", avm_chipselect, 0);
    check("arst_done", done, 0);
    check("arst_last", st_last, 0);
    check("arst_addr", avm_address, 0);
    sb.delete();
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_done_after_abort", done_cnt, d0);
    run_xfer(10'h040, 5, 0, 1'b0);

    // Single word from address 0 (keyed in the XOR build)
    ram[0] = 32'h0;
    run_xfer(10'h000, 1, 0, 1'b0);

    // Full RAM from 0x3FF, wrapping to 0x3FE
    run_xfer(10'h3FF, 1024, 0, 1'b0);
    if (addr_log.size() == 1024) check("full_last_addr", addr_log[1023], 10'h3FE);

    check("max_fill_le_depth", max_fill <= FIFO_DEPTH, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
